// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the MIPS control path: opcodes, functs, ALUOp codes, FSM states, mux selects.
// Used by both the multi-cycle controller and the single-cycle path.
package mc_ctrl_pkg;

  localparam int MC_ALUOP_W = 4;
  localparam int MC_STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SGT = 6'h29, FN_SLT = 6'h2A;

  localparam logic [MC_ALUOP_W-1:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2,
                                    ALU_OR  = 4'h3, ALU_SLT = 4'h4, ALU_XOR = 4'h5,
                                    ALU_NOR = 4'h6, ALU_SLL = 4'h7, ALU_SRL = 4'h8,
                                    ALU_SGT = 4'h9, ALU_NONE = 4'hF;

  typedef enum logic [MC_STATE_W-1:0] {
    S_RST    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,  S_WB_R   = 4'd5,  S_WB_I   = 4'd6,  S_MEM_ADDR = 4'd7,
    S_MEM_RD = 4'd8,  S_MEM_WR = 4'd9,  S_WB_MEM = 4'd10, S_BRANCH = 4'd11,
    S_JUMP   = 4'd12, S_JR     = 4'd13, S_TRAP   = 4'd14
  } state_t;

  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_BR = 2'b01, PCSRC_JMP = 2'b10, PCSRC_JR = 2'b11;
  localparam logic [1:0] REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS = 2'b01, SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;

  function automatic logic [MC_ALUOP_W-1:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI: return ALU_ADD;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decode: ALU operation, shamt-operand select, and whether the funct is supported.
// Purely combinational; no handshake.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]            funct,
  output logic [MC_ALUOP_W-1:0] alu_op,
  output logic                  shift_sel,
  output logic                  valid
);

  always_comb begin
    alu_op    = ALU_NONE;
    shift_sel = 1'b0;
    valid     = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_SLT: alu_op = ALU_SLT;
      FN_SGT: alu_op = ALU_SGT;
      FN_XOR: alu_op = ALU_XOR;
      FN_NOR: alu_op = ALU_NOR;
      FN_SLL: begin alu_op = ALU_SLL; shift_sel = 1'b1; end
      FN_SRL: begin alu_op = ALU_SRL; shift_sel = 1'b1; end
      FN_JR:  alu_op = ALU_NONE;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS controller; outputs decode from state and IR fields, memory states hold until mem_ready.
// MC_CTRL_TRAP_EN: unsupported instructions lock in TRAP until reset, otherwise they retire as a NOP.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr_en,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic               ir_wr_en,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_wr_en,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               invalid_inst
);

  logic [STATE_W-1:0]    state;
  state_t                dec_nxt;
  logic [MC_ALUOP_W-1:0] r_alu_op;
  logic                  r_shift;
  logic                  r_valid;

  mc_alu_decoder u_alu_dec (
    .funct     (funct),
    .alu_op    (r_alu_op),
    .shift_sel (r_shift),
    .valid     (r_valid)
  );

  // Anything not explicitly recognised falls through to TRAP.
  always_comb begin
    dec_nxt = S_TRAP;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) dec_nxt = S_JR;
        else if (r_valid)   dec_nxt = S_EXEC_R;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: dec_nxt = S_EXEC_I;
      OP_LW, OP_SW:   dec_nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE: dec_nxt = S_BRANCH;
      OP_J, OP_JAL:   dec_nxt = S_JUMP;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:      state <= S_FETCH;
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= dec_nxt;
        S_EXEC_R:   state <= S_WB_R;
        S_EXEC_I:   state <= S_WB_I;
        S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: state <= S_FETCH;
        S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
          state <= S_TRAP;
`else
          state <= S_FETCH;
`endif
        end
        default:    state <= S_RST;
      endcase
    end
  end

  always_comb begin
    pc_wr_en     = 1'b0;
    pc_src       = PCSRC_ALU;
    iord         = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    ir_wr_en     = 1'b0;
    reg_dst      = REGDST_RT;
    mem_to_reg   = M2R_ALU;
    reg_wr_en    = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RT;
    alu_op       = ALU_NONE;
    instr_done   = 1'b0;
    invalid_inst = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd_en = 1'b1;
        ir_wr_en  = mem_ready;
        pc_wr_en  = mem_ready;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = r_shift ? SRCA_SHAMT : SRCA_RS;
        alu_op    = r_alu_op;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op(opcode);
      end
      S_WB_R: begin
        reg_dst    = REGDST_RD;
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        iord      = 1'b1;
        mem_rd_en = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_wr_en  = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_MEM: begin
        mem_to_reg = M2R_MDR;
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_BR;
        pc_wr_en   = (opcode == OP_BEQ) ? zero : !zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JMP;
        pc_wr_en   = 1'b1;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
          reg_wr_en  = 1'b1;
        end
      end
      S_JR: begin
        pc_src     = PCSRC_JR;
        pc_wr_en   = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
        invalid_inst = 1'b1;
`else
        invalid_inst = 1'b1;
        instr_done   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus random instruction streams with random stalls.
// Expected per-cycle outputs come from an instruction-level sequence model.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_wr_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic       ir_wr_en;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_wr_en;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       invalid_inst;
  } outs_t;

  typedef struct {
    string tag;
    outs_t o;
    logic  mr;
    logic  z;
  } step_t;

  logic clk, rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_wr_en, iord, mem_rd_en, mem_wr_en, ir_wr_en, reg_wr_en, instr_done, invalid_inst;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
  logic [3:0] alu_op;
  outs_t obs;

  int checks = 0;
  int errors = 0;
  step_t q[$];
  logic [3:0] r_tab [logic [5:0]];
  logic [3:0] i_tab [logic [5:0]];

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr_en(pc_wr_en), .pc_src(pc_src), .iord(iord),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .ir_wr_en(ir_wr_en),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr_en(reg_wr_en),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .invalid_inst(invalid_inst)
  );

  assign obs = {pc_wr_en, pc_src, iord, mem_rd_en, mem_wr_en, ir_wr_en, reg_dst,
                mem_to_reg, reg_wr_en, alu_src_a, alu_src_b, alu_op, instr_done, invalid_inst};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.alu_op = 4'hF;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input string t, input outs_t o, input logic mr, input logic z);
    step_t s;
    s.tag = t; s.o = o; s.mr = mr; s.z = z;
    q.push_back(s);
  endtask

  task automatic chk(input string tag, input outs_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Expected cycle-by-cycle outputs for one instruction, from its class and stall counts.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int sf, input int sm);
    outs_t o;
    bit is_lw;
    q.delete();
    for (int i = 0; i < sf; i++) begin
      o = base(); o.mem_rd_en = 1; o.alu_src_b = 2'b01; o.alu_op = 4'h0;
      push("fetch_wait", o, 1'b0, rb());
    end
    o = base(); o.mem_rd_en = 1; o.alu_src_b = 2'b01; o.alu_op = 4'h0;
    o.ir_wr_en = 1; o.pc_wr_en = 1;
    push("fetch", o, 1'b1, rb());
    o = base(); o.alu_src_b = 2'b11; o.alu_op = 4'h0;
    push("decode", o, rb(), rb());
    if (op == 6'h00 && fn == 6'h08) begin
      o = base(); o.pc_src = 2'b11; o.pc_wr_en = 1; o.instr_done = 1;
      push("jr", o, rb(), rb());
    end else if (op == 6'h00 && r_tab.exists(fn)) begin
      o = base(); o.alu_src_a = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01;
      o.alu_op = r_tab[fn];
      push("exec_r", o, rb(), rb());
      o = base(); o.reg_dst = 2'b01; o.reg_wr_en = 1; o.instr_done = 1;
      push("wb_r", o, rb(), rb());
    end else if (i_tab.exists(op)) begin
      o = base(); o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = i_tab[op];
      push("exec_i", o, rb(), rb());
      o = base(); o.reg_wr_en = 1; o.instr_done = 1;
      push("wb_i", o, rb(), rb());
    end else if (op == 6'h23 || op == 6'h2B) begin
      is_lw = (op == 6'h23);
      o = base(); o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = 4'h0;
      push("mem_addr", o, rb(), rb());
      o = base(); o.iord = 1; o.mem_rd_en = is_lw; o.mem_wr_en = !is_lw;
      for (int i = 0; i < sm; i++) push("mem_wait", o, 1'b0, rb());
      o.instr_done = !is_lw;
      push("mem_done", o, 1'b1, rb());
      if (is_lw) begin
        o = base(); o.mem_to_reg = 2'b01; o.reg_wr_en = 1; o.instr_done = 1;
        push("wb_mem", o, rb(), rb());
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = base(); o.alu_src_a = 2'b01; o.alu_op = 4'h1; o.pc_src = 2'b01; o.instr_done = 1;
      o.pc_wr_en = (op == 6'h04) ? z : !z;
      push("branch", o, rb(), z);
    end else if (op == 6'h02 || op == 6'h03) begin
      o = base(); o.pc_src = 2'b10; o.pc_wr_en = 1; o.instr_done = 1;
      if (op == 6'h03) begin o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.reg_wr_en = 1; end
      push("jump", o, rb(), rb());
    end else begin
      o = base(); o.invalid_inst = 1;
`ifdef MC_CTRL_TRAP_EN
      for (int i = 0; i < 4; i++) push("trap_lock", o, rb(), rb());
`else
      o.instr_done = 1;
      push("trap", o, rb(), rb());
`endif
    end
  endtask

  // Called at posedge+1; each step drives, checks mid-cycle and advances to the next posedge+1.
  task automatic run_q(input string pfx, input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      mem_ready = q[i].mr;
      zero      = q[i].z;
      #2;
      chk($sformatf("%s_%s", pfx, q[i].tag), q[i].o);
      @(posedge clk); #1;
    end
  endtask

  task automatic exec(input string pfx, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input int sf, input int sm);
    opcode = op;
    funct  = fn;
    build(op, fn, z, sf, sm);
    run_q(pfx, q.size());
  endtask

  task automatic do_reset(input string pfx);
    rst_n = 1'b0;
    #1;
    chk({pfx, "_assert"}, base());
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = rb();
    #1;
    chk({pfx, "_release"}, base());
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] fns [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h29, 6'h26, 6'h27, 6'h00, 6'h02};
    logic [5:0] iops [5] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A};
    logic [5:0] bad [3]  = '{6'h3F, 6'h01, 6'h10};
    logic [5:0] op, fn;

    r_tab[6'h20] = 4'h0; r_tab[6'h22] = 4'h1; r_tab[6'h24] = 4'h2; r_tab[6'h25] = 4'h3;
    r_tab[6'h2A] = 4'h4; r_tab[6'h26] = 4'h5; r_tab[6'h27] = 4'h6; r_tab[6'h00] = 4'h7;
    r_tab[6'h02] = 4'h8; r_tab[6'h29] = 4'h9;
    i_tab[6'h08] = 4'h0; i_tab[6'h0C] = 4'h2; i_tab[6'h0D] = 4'h3; i_tab[6'h0E] = 4'h5;
    i_tab[6'h0A] = 4'h4;

    rst_n = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset("reset");

    exec("add", 6'h00, 6'h20, 1'b0, 0, 0);
    exec("lw_stall", 6'h23, 6'h00, 1'b0, 0, 3);
    exec("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
    exec("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0);
    exec("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
    exec("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0);
    exec("jal", 6'h03, 6'h00, 1'b0, 0, 0);
    exec("jr", 6'h00, 6'h08, 1'b0, 2, 0);
    exec("sll", 6'h00, 6'h00, 1'b0, 1, 0);
    exec("sw", 6'h2B, 6'h00, 1'b0, 0, 2);

    exec("bad_op", 6'h3F, 6'h00, 1'b0, 0, 0);
`ifdef MC_CTRL_TRAP_EN
    do_reset("trap_reset");
`endif
    exec("after_trap", 6'h0D, 6'h00, 1'b0, 0, 0);

    // Reset in the middle of a store stall must drop the write immediately.
    opcode = 6'h2B; funct = 6'h00;
    build(6'h2B, 6'h00, 1'b0, 0, 3);
    run_q("rst_sw", 4);
    mem_ready = 1'b0;
    #2;
    chk("rst_sw_stall", q[4].o);
    rst_n = 1'b0;
    #1;
    chk("rst_sw_drop", base());
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_sw_hold", base());
    @(posedge clk); #1;
    exec("post_rst", 6'h00, 6'h22, 1'b0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      fn = 6'h00;
      case ($urandom_range(0, 7))
        0, 1: begin op = 6'h00; fn = fns[$urandom_range(0, 9)]; end
        2:    begin op = 6'h00; fn = 6'h08; end
        3:    op = iops[$urandom_range(0, 4)];
        4:    op = rb() ? 6'h23 : 6'h2B;
        5:    op = rb() ? 6'h04 : 6'h05;
        6:    op = rb() ? 6'h02 : 6'h03;
        default: begin
`ifdef MC_CTRL_TRAP_EN
          op = iops[$urandom_range(0, 4)];
`else
          op = bad[$urandom_range(0, 2)];
          if (op == 6'h10) begin op = 6'h00; fn = 6'h01; end
`endif
        end
      endcase
      exec($sformatf("rnd%0d", n), op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
